pc_update_unit: RTL
===================

Name: pc_update_unit

Overview:
- Program-counter stage of the MiniRISC fetch path.
- Holds the architectural PC and selects the next PC each cycle: sequential (PC+4), PC-relative branch, or register jump.
- The branch offset input is the word-aligned offset produced by the shift-by-two stage directly upstream, so it arrives already multiplied by 4.
- Handles pipeline stalls by buffering a redirect that arrives during a stall, and supports halting the core.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_W, 32, width of PC and all address ports

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold PC this cycle (fetch/decode not ready)
halt_req  in  1  request to stop fetching permanently until reset
br_taken  in  1  PC-relative branch taken this cycle
br_offset  in  PC_W  signed byte offset, already shifted left by two upstream
jr_en  in  1  register-indirect jump this cycle
jr_target  in  PC_W  absolute jump target byte address
pc  out  PC_W  current PC (registered)
pc_plus4  out  PC_W  pc + 4, combinational from pc (link value)
halted  out  1  high while in HALT state (registered)
misalign  out  1  sticky flag: a redirect target had nonzero bits [1:0]

Behaviour:
- Reset (rst=1 at a clock edge, any state, overrides all inputs): pc=RESET_PC, state=RUN, pending cleared, halted=0, misalign=0. pc_plus4 therefore reads RESET_PC+4 in the cycle after reset.
- States: RUN, HOLD (redirect buffered during stall), HALT. Encoding is free; halted = (state==HALT).
- Redirect priority within a cycle: halt_req > jr_en > br_taken > sequential.
- Targets:
  - branch target = pc_plus4 + br_offset;
  - jump target = jr_target;
  - all sums are modulo 2^PC_W, with wrap-around silent (0xFFFF_FFFC + 4 = 0).
- Alignment: if target[1:0] != 0, the redirect is still taken with bits [1:0] forced to 00, and misalign is set to 1. misalign stays set until reset.
- RUN transitions:
  - halt_req=1 -> HALT; pc holds, regardless of stall.
  - stall=0 with a redirect -> pc <= target next edge (1-cycle latency).
  - stall=0 with no redirect -> pc <= pc+4.
  - stall=1 with no redirect -> pc holds.
  - stall=1 with a redirect -> pc holds; the target (already aligned) is latched into the pending register; state -> HOLD.
- HOLD transitions:
  - halt_req=1 -> HALT; pending is discarded.
  - stall=1 -> pc holds; new br_taken/jr_en are ignored (first redirect wins).
  - stall=0 -> pc <= pending; state -> RUN. A br_taken/jr_en in that same cycle is ignored.
- HALT: pc frozen, all inputs except rst ignored; only reset exits.
- Simultaneous jr_en and br_taken: jr_en wins. misalign is evaluated only on the winning target.
- br_taken/jr_en are single-cycle qualifiers; the unit does not require them to be held.

Test Plan:
1. Reset with RESET_PC=0, then 4 cycles of stall=0 and no redirects -> pc sequence 0, 4, 8, 12, 16; pc_plus4 = 20 at the end; halted=0, misalign=0.
2. At pc=0x10, br_taken=1 with br_offset=0x20 (upstream 8<<2) -> pc=0x34 next edge. At pc=0x34, br_taken=1 with br_offset=0xFFFF_FFF0 (-16) -> pc=0x28.
3. At pc=0x40, stall=1 and jr_en=1 with jr_target=0x100. Hold stall for 3 cycles while pulsing br_taken (offset 0x8), then release -> pc stays 0x40 throughout the stall, becomes 0x100 one edge after stall drops, and the br_taken pulse has no effect.
4. Same cycle jr_en=1 (target 0x200) and br_taken=1 (offset 0x4) at pc=0x0 -> pc=0x200. Then jr_en=1 with jr_target=0x203 -> pc=0x200 and misalign=1; misalign stays 1 over 10 further cycles.
5. At pc=0x20, halt_req=1 with stall=1 and a pending redirect -> halted=1 and pc=0x20 frozen for 20 cycles despite redirects. Then rst=1 for one edge -> pc=RESET_PC, halted=0, misalign=0.
6. Wrap-around: jr_target=0xFFFF_FFFC, then one sequential cycle -> pc=0x0000_0000. rst asserted in the middle of HOLD -> pending is lost and pc=RESET_PC after release.

Source files
------------

// File: rtl/pc_update_if.sv
// Fetch-path control bundle for the PC stage: stall/halt/redirect requests in,
// current PC, link value and status flags out.
interface pc_update_if #(
  parameter int PC_W = 32
);
  logic            stall;
  logic            halt_req;
  logic            br_taken;
  logic [PC_W-1:0] br_offset;
  logic            jr_en;
  logic [PC_W-1:0] jr_target;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;
  logic            halted;
  logic            misalign;

  // Requester side (fetch/decode control)
  modport master (
    output stall, halt_req, br_taken, br_offset, jr_en, jr_target,
    input  pc, pc_plus4, halted, misalign
  );

  // PC stage side
  modport slave (
    input  stall, halt_req, br_taken, br_offset, jr_en, jr_target,
    output pc, pc_plus4, halted, misalign
  );
endinterface

// File: rtl/pc_update_unit.sv
// Program-counter stage of the MiniRISC fetch path. Holds the architectural
// PC, picks sequential / branch / register-jump next PC, buffers a redirect
// seen during a stall (first redirect wins) and supports a permanent halt.
module pc_update_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        rst,
  pc_update_if.slave  bus
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(3'd4);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          state_r;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pending_r;
  logic            halted_r;
  logic            misalign_r;

  logic [PC_W-1:0] pc_plus4_s;
  logic            redir_s;
  logic [PC_W-1:0] raw_target_s;
  logic [PC_W-1:0] target_s;
  logic            target_misal_s;

  // Force a byte address onto a word boundary.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

  // Nonzero low bits mean the address was not word aligned.
  function automatic logic is_misaligned(input logic [PC_W-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  assign pc_plus4_s = pc_r + PC_STEP;

  // Redirect target selection: jump beats branch; offset is already in bytes.
  always_comb begin
    redir_s        = bus.jr_en | bus.br_taken;
    raw_target_s   = '0;
    if (bus.jr_en) begin
      raw_target_s = bus.jr_target;
    end else begin
      raw_target_s = pc_plus4_s + bus.br_offset;
    end
    target_s       = word_align(raw_target_s);
    target_misal_s = redir_s & is_misaligned(raw_target_s);
  end

  // PC state machine: RUN / HOLD (buffered redirect) / HALT, all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_RUN;
      pc_r       <= RESET_PC;
      pending_r  <= '0;
      halted_r   <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (bus.halt_req) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
          end else if (!bus.stall) begin
            if (redir_s) begin
              pc_r       <= target_s;
              misalign_r <= misalign_r | target_misal_s;
            end else begin
              pc_r <= pc_plus4_s;
            end
          end else if (redir_s) begin
            pending_r  <= target_s;
            misalign_r <= misalign_r | target_misal_s;
            state_r    <= ST_HOLD;
          end else begin
            pc_r <= pc_r;
          end
        end
        ST_HOLD: begin
          if (bus.halt_req) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
          end else if (!bus.stall) begin
            pc_r    <= pending_r;
            state_r <= ST_RUN;
          end else begin
            pc_r <= pc_r;
          end
        end
        ST_HALT: begin
          state_r  <= ST_HALT;
          halted_r <= 1'b1;
        end
        default: begin
          state_r  <= ST_RUN;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc       = pc_r;
  assign bus.pc_plus4 = pc_plus4_s;
  assign bus.halted   = halted_r;
  assign bus.misalign = misalign_r;

endmodule
